// File: rtl/change_dispenser_if.sv
// Handshake and status bundle between the transaction datapath/hopper and the change dispenser.
// master: drives requests, hopper ack and refills; slave: the dispenser itself.
// Pure wiring, no logic.
interface change_dispenser_if;
  logic        start;
  logic [15:0] change_amount;
  logic        coin_ack;
  logic        refill;
  logic [2:0]  refill_sel;
  logic        coin_valid;
  logic [2:0]  coin_sel;
  logic        busy;
  logic        done;
  logic [15:0] shortfall;
  logic        short_err;
  logic [15:0] paid_total;
  logic [19:0] hopper_count;

  modport master (
    output start, change_amount, coin_ack, refill, refill_sel,
    input  coin_valid, coin_sel, busy, done, shortfall, short_err, paid_total, hopper_count
  );

  modport slave (
    input  start, change_amount, coin_ack, refill, refill_sel,
    output coin_valid, coin_sel, busy, done, shortfall, short_err, paid_total, hopper_count
  );
endinterface

// File: rtl/change_dispenser.sv
// Greedy coin-by-coin change payout driving a hopper through a valid/ack handshake.
// Latency: start to done is 3 cycles for a zero amount; 2 cycles per coin with immediate ack.
// Backpressure: coin_valid/coin_sel are held until coin_ack; the FSM waits in ISSUE indefinitely.
module change_dispenser #(
  parameter logic [7:0] COIN0_VAL  = 8'd50,
  parameter logic [7:0] COIN1_VAL  = 8'd20,
  parameter logic [7:0] COIN2_VAL  = 8'd10,
  parameter logic [7:0] COIN3_VAL  = 8'd5,
  parameter logic [7:0] COIN4_VAL  = 8'd1,
  parameter logic [3:0] STOCK_INIT = 4'd15
) (
  input  logic              clk,
  input  logic              reset,
  change_dispenser_if.slave bus
);
  localparam int NUM_COINS = 5;

  typedef enum logic [1:0] {IDLE, SELECT, ISSUE, FINISH} state_t;

  state_t                    state;
  logic [15:0]               residual;
  logic [NUM_COINS-1:0][3:0] count;
  logic                      coin_valid;
  logic [2:0]                coin_sel;
  logic                      busy;
  logic                      done;
  logic [15:0]               shortfall;
  logic                      short_err;
  logic [15:0]               paid_total;
  logic                      pick_ok;
  logic [2:0]                pick_idx;
  logic [15:0]               issue_val;

  // Denominations must be nonzero, otherwise a nonzero residual could never shrink.
  function automatic logic [15:0] coin_value(input logic [2:0] idx);
    case (idx)
      3'd0:    coin_value = {8'd0, COIN0_VAL};
      3'd1:    coin_value = {8'd0, COIN1_VAL};
      3'd2:    coin_value = {8'd0, COIN2_VAL};
      3'd3:    coin_value = {8'd0, COIN3_VAL};
      3'd4:    coin_value = {8'd0, COIN4_VAL};
      default: coin_value = 16'd0;
    endcase
  endfunction

  // Greedy pick: scan from the smallest coin upward so the lowest eligible index wins.
  always_comb begin
    pick_ok  = 1'b0;
    pick_idx = 3'd0;
    for (int i = NUM_COINS - 1; i >= 0; i--) begin
      if (count[i] != 4'd0 && coin_value(3'(i)) <= residual) begin
        pick_ok  = 1'b1;
        pick_idx = 3'(i);
      end
    end
  end

  assign issue_val = coin_value(coin_sel);

  // Payout sequencer with registered outputs and hopper stock bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      residual   <= 16'd0;
      coin_valid <= 1'b0;
      coin_sel   <= 3'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      shortfall  <= 16'd0;
      short_err  <= 1'b0;
      paid_total <= 16'd0;
      for (int i = 0; i < NUM_COINS; i++) count[i] <= STOCK_INIT;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            residual   <= bus.change_amount;
            paid_total <= 16'd0;
            shortfall  <= 16'd0;
            short_err  <= 1'b0;
            busy       <= 1'b1;
            state      <= SELECT;
          end
        end
        SELECT: begin
          if (residual == 16'd0) begin
            state <= FINISH;
          end else if (pick_ok) begin
            coin_sel   <= pick_idx;
            coin_valid <= 1'b1;
            state      <= ISSUE;
          end else begin
            // Nothing in stock fits: report what is left unpaid.
            shortfall <= residual;
            short_err <= 1'b1;
            state     <= FINISH;
          end
        end
        ISSUE: begin
          if (bus.coin_ack) begin
            residual   <= residual - issue_val;
            paid_total <= paid_total + issue_val;
            if (count[coin_sel] != 4'd0) count[coin_sel] <= count[coin_sel] - 4'd1;
            coin_valid <= 1'b0;
            state      <= SELECT;
          end
        end
        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // Refill comes last so it overrides a same-cycle decrement of the same coin.
      if (bus.refill && bus.refill_sel < 3'd5) count[bus.refill_sel] <= STOCK_INIT;
    end
  end

  assign bus.coin_valid   = coin_valid;
  assign bus.coin_sel     = coin_sel;
  assign bus.busy         = busy;
  assign bus.done         = done;
  assign bus.shortfall    = shortfall;
  assign bus.short_err    = short_err;
  assign bus.paid_total   = paid_total;
  assign bus.hopper_count = count;
endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: constant vector table, hand-written corner
// sequences and a randomized run against a greedy arithmetic model of payouts and stock.
module tb_change_dispenser;
  logic clk;
  logic reset;
  change_dispenser_if bus();

  change_dispenser dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int VALS[5] = '{50, 20, 10, 5, 1};
  int mstock[5];
  int exp_coins[$];
  int exp_paid;
  int exp_short;

  int got[$];
  int done_cyc;
  int valid_seen;
  int hold_seen;
  logic err_at_done;
  logic [15:0] short_at_done;
  logic [15:0] paid_at_done;
  logic done_after;

  typedef struct {
    logic [15:0] amt;
    logic [15:0] paid;
    logic [15:0] short_amt;
    int          ncoins;
  } vec_t;
  vec_t tbl[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Greedy payout from the rules: largest fitting coin in stock, repeat until none fits.
  task automatic model_pay(input int amt);
    int  res;
    bit  found;
    exp_coins.delete();
    exp_paid = 0;
    res = amt;
    do begin
      found = 1'b0;
      for (int d = 0; d < 5; d++) begin
        if (!found && VALS[d] <= res && mstock[d] > 0) begin
          found = 1'b1;
          exp_coins.push_back(d);
          mstock[d]--;
          res      -= VALS[d];
          exp_paid += VALS[d];
        end
      end
    end while (found && res > 0);
    exp_short = res;
  endtask

  function automatic logic [19:0] model_hopper();
    logic [19:0] h;
    for (int d = 0; d < 5; d++) h[4*d +: 4] = 4'(mstock[d]);
    return h;
  endfunction

  task automatic do_reset();
    bus.start = 1'b0; bus.change_amount = 16'd0; bus.coin_ack = 1'b0;
    bus.refill = 1'b0; bus.refill_sel = 3'd0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst flags", {27'd0, bus.coin_valid, bus.busy, bus.done, bus.short_err, 1'b0}, 32'd0);
    check("rst coin_sel", {29'd0, bus.coin_sel}, 32'd0);
    check("rst shortfall/paid", {bus.shortfall, bus.paid_total}, 32'd0);
    check("rst hopper", {12'd0, bus.hopper_count}, 32'hFFFFF);
    @(negedge clk);
    reset = 1'b1;
    for (int d = 0; d < 5; d++) mstock[d] = 15;
  endtask

  // Issues one payout and plays the hopper. hold0: cycles to withhold ack on the first coin;
  // rnd: random ack delays and stray acks while no coin is presented; glitch: extra start while busy.
  task automatic run_payout(input logic [15:0] amt, input int hold0, input bit rnd, input bit glitch);
    int   cyc;
    int   held;
    bit   seen;
    bit   prev_wait;
    bit   allow;
    logic [2:0] prev_sel;
    got.delete();
    valid_seen = 0; hold_seen = 0; done_cyc = -1;
    @(negedge clk);
    bus.start = 1'b1; bus.change_amount = amt;
    @(negedge clk);
    bus.start = 1'b0; bus.change_amount = 16'($urandom);
    cyc = 1; held = 0; seen = 1'b0; prev_wait = 1'b0; prev_sel = 3'd0;
    while (!seen && cyc < 4000) begin
      if (bus.done) begin
        seen = 1'b1;
        done_cyc = cyc;
        err_at_done = bus.short_err;
        short_at_done = bus.shortfall;
        paid_at_done = bus.paid_total;
      end else begin
        if (glitch && cyc == 3) begin
          bus.start = 1'b1; bus.change_amount = 16'd10;
        end else begin
          bus.start = 1'b0;
        end
        if (bus.coin_valid) begin
          valid_seen++;
          if (prev_wait) check("coin_sel stable while waiting", {29'd0, bus.coin_sel}, {29'd0, prev_sel});
          if (got.size() == 0) allow = (held >= hold0);
          else allow = rnd ? ($urandom_range(0, 2) == 0) : 1'b1;
          if (allow) begin
            bus.coin_ack = 1'b1; got.push_back(int'(bus.coin_sel)); held = 0; prev_wait = 1'b0;
          end else begin
            bus.coin_ack = 1'b0; held++; hold_seen++; prev_wait = 1'b1; prev_sel = bus.coin_sel;
          end
        end else begin
          if (prev_wait) check("coin_valid held until ack", 32'd0, 32'd1);
          bus.coin_ack = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
          prev_wait = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
    end
    bus.coin_ack = 1'b0; bus.start = 1'b0;
    if (!seen) check("done timeout", 32'd0, 32'd1);
    @(negedge clk);
    done_after = bus.done;
  endtask

  task automatic verify(input string tag, input int paid, input int shrt, input logic [19:0] hop);
    int bad = -1;
    check({tag, " coin count"}, got.size(), exp_coins.size());
    for (int i = 0; i < got.size(); i++)
      if (bad < 0 && (i >= exp_coins.size() || got[i] != exp_coins[i])) bad = i;
    check({tag, " first wrong coin index"}, bad, -1);
    check({tag, " paid_total"}, {16'd0, paid_at_done}, paid);
    check({tag, " shortfall"}, {16'd0, short_at_done}, shrt);
    check({tag, " short_err"}, {31'd0, err_at_done}, {31'd0, shrt != 0});
    check({tag, " hopper"}, {12'd0, bus.hopper_count}, {12'd0, hop});
    check({tag, " done one cycle"}, {31'd0, done_after}, 32'd0);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!bus.coin_valid && n < 50) begin @(negedge clk); n++; end
    if (!bus.coin_valid) check({tag, " coin_valid timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    tbl[0]  = '{16'd87,    16'd87,   16'd0,     6};
    tbl[1]  = '{16'd0,     16'd0,    16'd0,     0};
    tbl[2]  = '{16'd800,   16'd800,  16'd0,     18};
    tbl[3]  = '{16'd1,     16'd1,    16'd0,     1};
    tbl[4]  = '{16'd4,     16'd4,    16'd0,     4};
    tbl[5]  = '{16'd7,     16'd7,    16'd0,     3};
    tbl[6]  = '{16'd49,    16'd49,   16'd0,     7};
    tbl[7]  = '{16'd1000,  16'd1000, 16'd0,     28};
    tbl[8]  = '{16'd1300,  16'd1290, 16'd10,    75};
    tbl[9]  = '{16'd65535, 16'd1290, 16'd64245, 75};
    tbl[10] = '{16'd3,     16'd3,    16'd0,     3};

    reset = 1'b0;
    do_reset();

    // Constant vectors, each from fresh stock; done timing follows 3 + 2 cycles per coin.
    for (int i = 0; i < 11; i++) begin
      do_reset();
      model_pay(int'(tbl[i].amt));
      run_payout(tbl[i].amt, 0, 1'b0, 1'b0);
      check($sformatf("tbl%0d paid", i), {16'd0, paid_at_done}, {16'd0, tbl[i].paid});
      check($sformatf("tbl%0d shortfall", i), {16'd0, short_at_done}, {16'd0, tbl[i].short_amt});
      check($sformatf("tbl%0d coins", i), got.size(), tbl[i].ncoins);
      check($sformatf("tbl%0d done latency", i), done_cyc, 3 + 2 * tbl[i].ncoins);
      verify($sformatf("tbl%0d", i), exp_paid, exp_short, model_hopper());
    end

    // Scenario 1 and 2: 87 then a zero payout on the depleted stock.
    do_reset();
    run_payout(16'd87, 0, 1'b0, 1'b0);
    exp_coins = {0, 1, 2, 3, 4, 4};
    verify("s1", 87, 0, 20'hDEEEE);
    run_payout(16'd0, 0, 1'b0, 1'b0);
    exp_coins.delete();
    verify("s2", 0, 0, 20'hDEEEE);
    check("s2 done latency", done_cyc, 3);
    check("s2 no coin_valid", valid_seen, 0);

    // Scenario 3: exhausting the 50s.
    do_reset();
    run_payout(16'd800, 0, 1'b0, 1'b0);
    exp_coins.delete();
    for (int i = 0; i < 15; i++) exp_coins.push_back(0);
    exp_coins.push_back(1); exp_coins.push_back(1); exp_coins.push_back(2);
    verify("s3", 800, 0, 20'hFFED0);

    // Scenario 4: running out of ones leaves a shortfall.
    do_reset();
    for (int k = 0; k < 3; k++) run_payout(16'd4, 0, 1'b0, 1'b0);
    run_payout(16'd4, 0, 1'b0, 1'b0);
    exp_coins = {4, 4, 4};
    verify("s4", 3, 1, 20'h0FFFF);
    repeat (3) @(negedge clk);
    check("s4 short_err held", {31'd0, bus.short_err}, 32'd1);
    check("s4 shortfall held", {16'd0, bus.shortfall}, 32'd1);
    run_payout(16'd0, 0, 1'b0, 1'b0);
    exp_coins.delete();
    verify("s4 next start clears", 0, 0, 20'h0FFFF);

    // Scenario 5: slow first ack plus an ignored start while busy.
    do_reset();
    run_payout(16'd87, 5, 1'b0, 1'b1);
    exp_coins = {0, 1, 2, 3, 4, 4};
    verify("s5", 87, 0, 20'hDEEEE);
    check("s5 hold cycles", hold_seen, 5);

    // Scenario 6: asynchronous reset in ISSUE, then refill racing an ack.
    do_reset();
    run_payout(16'd87, 0, 1'b0, 1'b0);
    @(negedge clk);
    bus.start = 1'b1; bus.change_amount = 16'd87;
    @(negedge clk);
    bus.start = 1'b0;
    wait_valid("s6");
    #2 reset = 1'b0;
    #1;
    check("s6 async coin_valid", {31'd0, bus.coin_valid}, 32'd0);
    check("s6 async busy", {31'd0, bus.busy}, 32'd0);
    check("s6 async hopper", {12'd0, bus.hopper_count}, 32'hFFFFF);
    check("s6 async paid", {16'd0, bus.paid_total}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int d = 0; d < 5; d++) mstock[d] = 15;
    @(negedge clk);
    check("s6 idle after reset", {30'd0, bus.busy, bus.coin_valid}, 32'd0);
    @(negedge clk);
    bus.start = 1'b1; bus.change_amount = 16'd1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_valid("s6b");
    check("s6b coin_sel", {29'd0, bus.coin_sel}, 32'd4);
    bus.coin_ack = 1'b1; bus.refill = 1'b1; bus.refill_sel = 3'd4;
    @(negedge clk);
    bus.coin_ack = 1'b0; bus.refill = 1'b0;
    check("s6b refill beats ack", {28'd0, bus.hopper_count[19:16]}, 32'd15);
    begin
      int n = 0;
      while (!bus.done && n < 10) begin @(negedge clk); n++; end
      check("s6b done seen", {31'd0, bus.done}, 32'd1);
      check("s6b paid", {16'd0, bus.paid_total}, 32'd1);
    end
    run_payout(16'd1, 0, 1'b0, 1'b0);
    exp_coins = {4};
    verify("s6c", 1, 0, 20'hEFFFF);
    bus.refill = 1'b1; bus.refill_sel = 3'd7;
    @(negedge clk);
    bus.refill = 1'b0;
    check("s6 refill sel 7 ignored", {12'd0, bus.hopper_count}, 32'hEFFFF);
    bus.refill = 1'b1; bus.refill_sel = 3'd4;
    @(negedge clk);
    bus.refill = 1'b0;
    check("s6 refill sel 4", {12'd0, bus.hopper_count}, 32'hFFFFF);

    // Randomized payouts on evolving stock with idle-time refills.
    do_reset();
    for (int it = 0; it < 30; it++) begin
      int amt;
      if ($urandom_range(0, 2) == 0) begin
        int sel;
        sel = $urandom_range(0, 7);
        bus.refill = 1'b1; bus.refill_sel = 3'(sel);
        @(negedge clk);
        bus.refill = 1'b0;
        if (sel < 5) mstock[sel] = 15;
      end
      amt = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 250);
      model_pay(amt);
      run_payout(16'(amt), $urandom_range(0, 3), 1'b1, 1'b0);
      verify($sformatf("rnd%0d amt=%0d", it, amt), exp_paid, exp_short, model_hopper());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
Pays out a purchase's change, coin by coin, after the transaction datapath has computed the remaining amount.
- Accepts a 16-bit change amount with a start pulse.
- Greedily selects the largest available denomination and drives a coin hopper through a valid/ack handshake.
- Tracks per-denomination hopper stock, which resets to 15 and can be refilled.
- Reports completion, the total paid out, and any shortfall when exact change cannot be made.

Parameters:
COIN0_VAL, 50, value of denomination 0 (largest); 8-bit
COIN1_VAL, 20, value of denomination 1
COIN2_VAL, 10, value of denomination 2
COIN3_VAL, 5, value of denomination 3
COIN4_VAL, 1, value of denomination 4 (smallest)
STOCK_INIT, 15, hopper count per denomination after reset or refill; 4-bit

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (one clock domain)
start  input  1  single-cycle request; sampled only in IDLE
change_amount  input  16  amount to pay out; latched when start is accepted
coin_ack  input  1  hopper has taken the presented coin
refill  input  1  restore hopper stock of the denomination given by refill_sel to STOCK_INIT
refill_sel  input  3  denomination index 0..4; values 5..7 are ignored
coin_valid  output  1  a coin request is presented
coin_sel  output  3  denomination index of the presented coin
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse at the end of a payout
shortfall  output  16  unpaid residual of the last payout; 0 when change was exact
short_err  output  1  set with done when shortfall is nonzero; held until the next accepted start
paid_total  output  16  sum paid out in the current or last payout
hopper_count  output  20  packed 4-bit stock per denomination, [3:0]=denomination 0 ... [19:16]=denomination 4

Behaviour:
- Reset (reset=0, asynchronous) puts the block in this state immediately, including mid-payout:
  - state=IDLE
  - coin_valid, busy and done = 0
  - coin_sel=0, shortfall=0, short_err=0, paid_total=0
  - all hopper counts=STOCK_INIT
- FSM states: IDLE, SELECT, ISSUE, FINISH.
- IDLE, start=1: latch residual=change_amount, clear paid_total, shortfall and short_err, go to SELECT. start in any other state is ignored.
- SELECT (1 cycle):
  - residual==0 -> FINISH.
  - Otherwise pick the lowest index d with value(d)<=residual and count(d)>0; register coin_sel=d and go to ISSUE.
  - If no such d exists -> shortfall=residual, short_err=1, go to FINISH.
- ISSUE:
  - coin_valid=1; coin_sel stays stable until the ack.
  - On a cycle with coin_ack=1: residual -= value(d), paid_total += value(d), count(d) -= 1, coin_valid drops next cycle, go to SELECT.
  - Without ack: stay in ISSUE indefinitely.
- FINISH (1 cycle): done=1, then go to IDLE.
- coin_ack outside ISSUE is ignored.
- Throughput: 2 cycles per coin when ack is returned in the first ISSUE cycle.
- Latency: start to done for a zero amount is 3 cycles (IDLE, SELECT, FINISH edges).
- Arithmetic: residual is 16-bit unsigned and never underflows, because selection guarantees value<=residual. paid_total plus the final shortfall always equals the latched change_amount.
- Refill:
  - Applies in any state.
  - On the same cycle as an acked decrement of the same denomination, refill wins and the count becomes STOCK_INIT.
  - A refill during SELECT affects the following SELECT only.
- Counts saturate at 0; a denomination with count 0 is never selected.

Test Plan:
1. Reset, start with change_amount=87, ack every ISSUE cycle -> coin_sel sequence 0,1,2,3,4,4; paid_total=87; shortfall=0; done pulse; counts 14,14,14,14,13.
2. change_amount=0 -> no coin_valid; done exactly 3 cycles after start; short_err=0.
3. Reset, change_amount=800 -> 15 coins of sel 0, then sel 1,1,2; count0=0; paid_total=800; shortfall=0.
4. Reset, three payouts of 4 (12 ones) then change_amount=4 -> three sel 4 coins; shortfall=1; short_err=1 with done; count4=0.
5. Change_amount=87, hold coin_ack low 5 cycles on the first coin -> coin_valid and coin_sel=0 stay stable. A start pulse during busy is ignored. Final result matches scenario 1.
6. Pull reset low while in ISSUE -> coin_valid=0 immediately, counts=15, state IDLE. Refill sel 4 coincident with an ack of sel 4 -> count4=15.
